// File: rtl/block_mac_2x2_unit_if.sv
// rtl/block_mac_2x2_unit_if.sv - start/done handshake, operand and result bundle for the 2x2 block MAC
interface block_mac_2x2_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              acc_en;
  logic [DATA_W-1:0] a_11, a_12, a_21, a_22;
  logic [DATA_W-1:0] b_11, b_12, b_21, b_22;
  logic [DATA_W-1:0] c_11, c_12, c_21, c_22;
  logic              busy;
  logic              done;

  modport master (
    output start, acc_en, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    input  c_11, c_12, c_21, c_22, busy, done
  );

  modport slave (
    input  start, acc_en, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    output c_11, c_12, c_21, c_22, busy, done
  );
endinterface

// File: rtl/block_mac_2x2_unit.sv
// rtl/block_mac_2x2_unit.sv - 2x2 block multiply/accumulate on one shared registered multiplier
module block_mac_2x2_unit #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  block_mac_2x2_unit_if.slave  mac_if
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        p_q, p_d;
  logic              start_q;
  logic [DATA_W-1:0] a_q   [4];
  logic [DATA_W-1:0] b_q   [4];
  logic [DATA_W-1:0] acc_q [4];
  logic [DATA_W-1:0] c_q   [4];
  logic [DATA_W-1:0] mul_q;
  logic              start_edge;
  logic [1:0]        tgt;
  logic [DATA_W-1:0] op_a, op_b, prod;

  assign start_edge = mac_if.start & ~start_q;

  // Operand index {row,col}: p walks a11*b11, a12*b21, a11*b12, a12*b22, then the same for row 2
  assign op_a = a_q[{p_q[2], p_q[0]}];
  assign op_b = b_q[{p_q[0], p_q[1]}];
  assign prod = op_a * op_b;

  // Accumulator fed this cycle by the product registered on the previous cycle
  always_comb begin
    tgt = 2'd3;
    case (p_q)
      3'd1, 3'd2: tgt = 2'd0;
      3'd3, 3'd4: tgt = 2'd1;
      3'd5, 3'd6: tgt = 2'd2;
      default:    tgt = 2'd3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_MUL;
          p_d     = 3'd0;
        end
      end
      S_MUL: begin
        p_d = p_q + 3'd1;
        if (p_q == 3'd7) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= 3'd0;
      start_q <= 1'b0;
      mul_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        acc_q[i] <= '0;
        c_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      start_q <= mac_if.start;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            a_q[0] <= mac_if.a_11;  a_q[1] <= mac_if.a_12;
            a_q[2] <= mac_if.a_21;  a_q[3] <= mac_if.a_22;
            b_q[0] <= mac_if.b_11;  b_q[1] <= mac_if.b_12;
            b_q[2] <= mac_if.b_21;  b_q[3] <= mac_if.b_22;
            for (int i = 0; i < 4; i++)
              acc_q[i] <= mac_if.acc_en ? c_q[i] : '0;
          end
        end
        S_MUL: begin
          mul_q <= prod;
          if (p_q != 3'd0) acc_q[tgt] <= acc_q[tgt] + mul_q;
        end
        S_DRAIN: begin
          acc_q[3] <= acc_q[3] + mul_q;
          c_q[0]   <= acc_q[0];
          c_q[1]   <= acc_q[1];
          c_q[2]   <= acc_q[2];
          c_q[3]   <= acc_q[3] + mul_q;
        end
        default: ;
      endcase
    end
  end

  assign mac_if.c_11 = c_q[0];
  assign mac_if.c_12 = c_q[1];
  assign mac_if.c_21 = c_q[2];
  assign mac_if.c_22 = c_q[3];
  assign mac_if.busy = (state_q != S_IDLE);
  assign mac_if.done = (state_q == S_DONE);
endmodule
